// File: rtl/db_pkg.sv
// Shared types and defaults for the two-channel switch debouncer.
// Holds the per-channel state encoding and the Moore output decode.
package db_pkg;

  // 20 ms at 100 MHz
  localparam int DB_TICKS_DEFAULT = 2_000_000;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

  // Debounced level: high once a rising edge has been accepted and until a fall is accepted.
  function automatic logic db_level(input db_state_t s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: 2-flop synchronizer, ZERO/WAIT1/ONE/WAIT0 FSM, down-counter, rising-edge tick.
// Latency DB_TICKS+3 edges for a clean step in either direction; no backpressure, output is a free-running level.
module db_channel
  import db_pkg::*;
#(
  parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic tick
);

  localparam int            CW       = $clog2(DB_TICKS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          tick_q, tick_d;

  always_comb begin
    meta_d  = raw;
    sync_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;

    // The counter is only decremented while non-zero, so it never wraps.
    case (state_q)
      ZERO: begin
        if (sync_q) begin
          state_d = WAIT1;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!sync_q) begin
          state_d = ZERO;
        end else if (cnt_q == '0) begin
          state_d = ONE;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ONE: begin
        if (!sync_q) begin
          state_d = WAIT0;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (sync_q) begin
          state_d = ONE;
        end else if (cnt_q == '0) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase

    db_d = db_level(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= ZERO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      tick_q  <= tick_d;
    end
  end

  assign db   = db_q;
  assign tick = tick_q;

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce channels (a, b) for bouncing switch/button inputs.
// Latency DB_TICKS+3 edges per clean step; no backpressure, outputs are levels plus one-cycle rising ticks.
module input_debouncer
  import db_pkg::*;
#(
  parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_tick,
  output logic b_tick
);

  db_channel #(.DB_TICKS(DB_TICKS)) u_ch_a (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (a_raw),
    .db      (a_db),
    .tick    (a_tick)
  );

  db_channel #(.DB_TICKS(DB_TICKS)) u_ch_b (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (b_raw),
    .db      (b_db),
    .tick    (b_tick)
  );

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DB_TICKS=4; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_input_debouncer;

  logic clk;
  logic reset_n;
  logic a_raw;
  logic b_raw;
  logic a_db;
  logic b_db;
  logic a_tick;
  logic b_tick;

  int n_checks = 0;
  int n_fail   = 0;

  input_debouncer #(.DB_TICKS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a_raw   (a_raw),
    .b_raw   (b_raw),
    .a_db    (a_db),
    .b_db    (b_db),
    .a_tick  (a_tick),
    .b_tick  (b_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_raw   = 1'b0;
    b_raw   = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_raw   = 1'b0;
    b_raw   = 1'b0;
    #1;
    n_checks++;
    if ({a_db, b_db, a_tick, b_tick} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: {a_db,b_db,a_tick,b_tick}=%b expected 0000", {a_db, b_db, a_tick, b_tick});
    end
    step(2);
    reset_n = 1'b1;
    step(3);
    n_checks++;
    if ({a_db, b_db, a_tick, b_tick} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: {a_db,b_db,a_tick,b_tick}=%b expected 0000", {a_db, b_db, a_tick, b_tick});
    end
  endtask

  task automatic test_clean_edge();
    do_reset();
    a_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      n_checks++;
      if (a_db !== (i >= 7) || a_tick !== (i == 7)) begin
        n_fail++;
        $display("FAIL clean_rise edge %0d: a_db=%b a_tick=%b expected a_db=%b a_tick=%b",
                 i, a_db, a_tick, (i >= 7), (i == 7));
      end
      n_checks++;
      if (b_db !== 1'b0 || b_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_rise_b_quiet edge %0d: b_db=%b b_tick=%b expected 0 0", i, b_db, b_tick);
      end
    end
    a_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      n_checks++;
      if (a_db !== (i < 7) || a_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_fall edge %0d: a_db=%b a_tick=%b expected a_db=%b a_tick=0",
                 i, a_db, a_tick, (i < 7));
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    a_raw = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (i == 3) a_raw = 1'b0;
      n_checks++;
      if (a_db !== 1'b0 || a_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch edge %0d: a_db=%b a_tick=%b expected 0 0", i, a_db, a_tick);
      end
    end
  endtask

  task automatic test_release_bounce();
    do_reset();
    a_raw = 1'b1;
    step(10);
    n_checks++;
    if (a_db !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_setup: a_db=%b expected 1", a_db);
    end
    // low 2, high 1, then low held; the final fall is first sampled on edge 4
    a_raw = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step(1);
      if (i == 2) a_raw = 1'b1;
      if (i == 3) a_raw = 1'b0;
      n_checks++;
      if (a_db !== (i < 10) || a_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL release_bounce edge %0d: a_db=%b a_tick=%b expected a_db=%b a_tick=0",
                 i, a_db, a_tick, (i < 10));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      n_checks++;
      if (a_db !== (i >= 7) || b_db !== (i >= 7) || a_tick !== (i == 7) || b_tick !== (i == 7)) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d: a_db=%b b_db=%b a_tick=%b b_tick=%b expected db=%b tick=%b",
                 i, a_db, b_db, a_tick, b_tick, (i >= 7), (i == 7));
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    a_raw = 1'b1;
    step(4);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (a_db !== 1'b0 || a_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: a_db=%b a_tick=%b expected 0 0", a_db, a_tick);
    end
    #3 reset_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      n_checks++;
      if (a_db !== (i >= 7) || a_tick !== (i == 7)) begin
        n_fail++;
        $display("FAIL mid_reset_restart edge %0d: a_db=%b a_tick=%b expected a_db=%b a_tick=%b",
                 i, a_db, a_tick, (i >= 7), (i == 7));
      end
    end
  endtask

  task automatic test_async_reset_from_one();
    do_reset();
    a_raw = 1'b1;
    b_raw = 1'b1;
    step(10);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({a_db, b_db, a_tick, b_tick} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_from_one: {a_db,b_db,a_tick,b_tick}=%b expected 0000",
               {a_db, b_db, a_tick, b_tick});
    end
    #2 reset_n = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;
    step(2);
  endtask

  task automatic test_hold();
    int ticks;
    ticks = 0;
    do_reset();
    a_raw = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (a_tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks !== 1) begin
      n_fail++;
      $display("FAIL hold_tick_count: a_tick pulses=%0d expected 1", ticks);
    end
    n_checks++;
    if (a_db !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_level: a_db=%b expected 1", a_db);
    end
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_glitch();
    test_release_bounce();
    test_simultaneous();
    test_mid_reset();
    test_async_reset_from_one();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
